// File: rtl/lap_stopwatch.sv
// lap_stopwatch: self-timed m:ss.t stopwatch with run/stop and lap/clear buttons,
// driving three 7-segment digits and a one-hot tenths bar.
module lap_stopwatch #(
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 10,
    parameter int MIN_MAX        = 9,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap_clear,
    output logic [6:0] left,
    output logic [6:0] right,
    output logic [6:0] minseg,
    output logic [9:0] msled,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t        state, state_nx;
    logic [2:0]    ss_sync, lc_sync;
    logic          ss_rise, lc_rise;
    logic [PW-1:0] pre;
    logic          counting, clear, tick;
    logic [3:0]    tn, su, mn;
    logic [2:0]    st;
    logic          tn_c, su_c, st_c, at_max;
    logic [14:0]   snap, live, src;
    logic          running_d, lap_d;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [9:0] bar(input logic [3:0] d);
        return d < 4'd10 ? 10'b1 << d : 10'b0;
    endfunction

    // sync2 & ~sync3 edge detect; start_stop wins a same-cycle collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_sync <= '0;
            lc_sync <= '0;
        end else begin
            ss_sync <= {ss_sync[1:0], start_stop};
            lc_sync <= {lc_sync[1:0], lap_clear};
        end
    end

    assign ss_rise = ss_sync[1] & ~ss_sync[2];
    assign lc_rise = lc_sync[1] & ~lc_sync[2] & ~ss_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = ss_rise ? RUN : IDLE;
            RUN:  state_nx = ss_rise ? STOP : lc_rise ? LAP : RUN;
            LAP:  state_nx = ss_rise ? STOP : lc_rise ? RUN : LAP;
            STOP: state_nx = ss_rise ? RUN : lc_rise ? IDLE : STOP;
        endcase
    end

    always_comb begin
        running_d = state == RUN || state == LAP;
        lap_d     = state == LAP;
        src       = lap_d ? snap : live;
    end

    assign counting = running_d;
    assign clear    = state == IDLE || (state == STOP && lc_rise);
    assign tick     = counting && pre == PW'(DIV - 1);

    // STOP holds the prescaler so a resume finishes the interrupted tenth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pre <= '0;
        else if (clear)    pre <= '0;
        else if (counting) pre <= tick ? '0 : pre + PW'(1);
    end

    assign tn_c   = tn == 4'(TICK_HZ - 1);
    assign su_c   = su == 4'd9;
    assign st_c   = st == 3'd5;
    assign at_max = tn_c && su_c && st_c && mn == 4'(MIN_MAX);
    assign live   = {mn, st, su, tn};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {mn, st, su, tn} <= '0;
            overflow         <= 1'b0;
        end else if (clear) begin
            {mn, st, su, tn} <= '0;
            overflow         <= 1'b0;
        end else if (tick) begin
            if (at_max) overflow <= 1'b1;
            else begin
                tn <= tn_c ? 4'd0 : tn + 4'd1;
                if (tn_c) su <= su_c ? 4'd0 : su + 4'd1;
                if (tn_c && su_c) st <= st_c ? 3'd0 : st + 3'd1;
                if (tn_c && su_c && st_c) mn <= mn + 4'd1;
            end
        end
    end

    // captures the pre-tick count when a lap coincides with a tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     snap <= '0;
        else if (state == RUN && lc_rise) snap <= live;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left       <= seg(4'd0);
            right      <= seg(4'd0);
            minseg     <= seg(4'd0);
            msled      <= bar(4'd0);
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            left       <= seg({1'b0, src[10:8]});
            right      <= seg(src[7:4]);
            minseg     <= seg(src[14:11]);
            msled      <= bar(src[3:0]);
            running    <= running_d;
            lap_active <= lap_d;
        end
    end
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: directed scoreboard bench for lap_stopwatch at 100 Hz clock, 10 Hz tick.
module tb_lap_stopwatch;
    logic       clk = 1'b0, rst_n = 1'b0, ss = 1'b0, lc = 1'b0;
    logic [6:0] left, right, minseg;
    logic [9:0] msled;
    logic       running, lap_active, overflow;
    int         cyc = 0;
    int         compared = 0, mismatched = 0;
    int         s, x, l, r, y;

    // active-low {g..a} glyphs for 0..9
    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {string tag; int id; logic [31:0] exp;} item_t;
    item_t sb[$];

    lap_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .MIN_MAX(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(rst_n), .start_stop(ss), .lap_clear(lc),
        .left(left), .right(right), .minseg(minseg), .msled(msled),
        .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] obs(input int id);
        case (id)
            0:       return 32'(left);
            1:       return 32'(right);
            2:       return 32'(minseg);
            3:       return 32'(msled);
            4:       return 32'(running);
            5:       return 32'(lap_active);
            default: return 32'(overflow);
        endcase
    endfunction

    task automatic want(input string tag, input int id, input logic [31:0] e);
        item_t it;
        it.tag = tag; it.id = id; it.exp = e;
        sb.push_back(it);
    endtask

    task automatic want_time(input string tag, input int t);
        logic [9:0] one;
        one = 10'b1;
        want({tag, ".left"},   0, 32'(GLYPH[(t / 100) % 6]));
        want({tag, ".right"},  1, 32'(GLYPH[(t / 10) % 10]));
        want({tag, ".minseg"}, 2, 32'(GLYPH[t / 600]));
        want({tag, ".msled"},  3, 32'(one << (t % 10)));
    endtask

    task automatic want_flags(input string tag, input bit rn, input bit la, input bit ov);
        want({tag, ".running"},    4, 32'(rn));
        want({tag, ".lap_active"}, 5, 32'(la));
        want({tag, ".overflow"},   6, 32'(ov));
    endtask

    task automatic check();
        item_t       it;
        logic [31:0] o;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            o = obs(it.id);
            compared++;
            assert (o === it.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // returns the index of the clk edge at which the FSM acts on the press
    task automatic press(input bit s_in, input bit l_in, input int hold, output int edge_o);
        ss = s_in; lc = l_in;
        repeat (3) @(negedge clk);
        edge_o = cyc;
        repeat (hold - 3) @(negedge clk);
        ss = 1'b0; lc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        want_time("reset", 0); want_flags("reset", 0, 0, 0); check();
        rst_n = 1'b1;
        @(negedge clk);

        // 1: start, button held 30 clk must toggle only once
        press(1, 0, 30, s);
        want_flags("t1.held", 1, 0, 0); want_time("t1.held", (cyc - 1 - s) / 10); check();
        wait_to(s + 101);
        want_time("t1.1s", 10); check();

        // 2: minute carry and overflow hold
        wait_to(s + 5996);  want_time("t2.059", 599); check();
        wait_to(s + 6006);  want_time("t2.100", 600); check();
        wait_to(s + 11996); want_time("t2.159", 1199); want_flags("t2.159", 1, 0, 0); check();
        wait_to(s + 12006); want_time("t2.ovf", 1199); want_flags("t2.ovf", 1, 0, 1); check();
        press(1, 0, 3, x);
        wait_to(x + 2); want_time("t2.stop", 1199); want_flags("t2.stop", 0, 0, 1); check();
        press(0, 1, 3, x);
        wait_to(x + 2); want_time("t2.clr", 0); want_flags("t2.clr", 0, 0, 0); check();

        // 3: lap at 0:03.4 freezes display, second lap returns to live
        press(1, 0, 3, s);
        wait_to(s + 342);
        press(0, 1, 3, l);
        wait_to(l + 50); want_time("t3.lap", 34); want_flags("t3.lap", 1, 1, 0); check();
        press(0, 1, 3, r);
        wait_to(r + 2); want_time("t3.live", (cyc - 1 - s) / 10); want_flags("t3.live", 1, 0, 0); check();
        want_time("t3.039", 39); check();
        press(1, 0, 3, x);
        press(0, 1, 3, x);

        // 4: stop at 2.0 + 4 prescaler counts, resume finishes the tenth in 6 clk
        press(1, 0, 3, s);
        wait_to(s + 201);
        press(1, 0, 3, x);
        wait_to(x + 200); want_time("t4.stop", 20); want_flags("t4.stop", 0, 0, 0); check();
        press(1, 0, 3, r);
        wait_to(r + 6); want_time("t4.r6", 20); check();
        wait_to(r + 7); want_time("t4.r7", 21); want_flags("t4.r7", 1, 0, 0); check();

        // 5: simultaneous edges in RUN -> STOP; then lap_clear clears to IDLE
        press(1, 1, 3, x);
        wait_to(x + 2); want_flags("t5.both", 0, 0, 0); check();
        press(0, 1, 3, y);
        wait_to(y + 2); want_time("t5.idle", 0); want_flags("t5.idle", 0, 0, 0); check();

        // 6: asynchronous reset while in LAP with overflow set
        press(1, 0, 3, s);
        wait_to(s + 12006); want_flags("t6.ovf", 1, 0, 1); check();
        press(0, 1, 3, l);
        wait_to(l + 3); want_time("t6.lap", 1199); want_flags("t6.lap", 1, 1, 1); check();
        #2 rst_n = 1'b0;
        #1 want_time("t6.rst", 0); want_flags("t6.rst", 0, 0, 0); check();
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        want_time("t6.idle", 0); want_flags("t6.idle", 0, 0, 0); check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
